// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC writer: FSM state encoding, frame geometry
// and the helper that assembles the 16-bit DAC frame.
package spi_dac_pkg;

    localparam int          FRAME_BITS  = 16;
    localparam int          BIT_CNT_W   = $clog2(FRAME_BITS);
    localparam logic [3:0]  DEFAULT_CMD = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_LDAC
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cmd,
                                                          input logic [7:0] code);
        return {cmd, code, 4'b0000};
    endfunction

endpackage

// File: rtl/spi_dac_tx_if.sv
// Request/status handshake between the sweep controller (master) and the DAC writer (slave).
interface spi_dac_tx_if;

    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       done;

    modport master (output start, output data, input busy, input done);
    modport slave  (input start, input data, output busy, output done);

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV clk cycles while enabled, idles low otherwise.
// The ticks flag the cycle just before sclk rises or falls.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap      = en && (cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap &&  sclk;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dac_tx.sv
// SPI mode-0 writer: sends {CMD, code, 4'b0} MSB first per accepted request.
// Optional LDAC strobe after cs_n rises is enabled with `define SPI_DAC_LDAC_EN.
module spi_dac_tx
    import spi_dac_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         CS_SETUP   = 2,
    parameter int         CS_HOLD    = 2,
    parameter logic [3:0] CMD        = DEFAULT_CMD,
    parameter int         LDAC_WIDTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    spi_dac_tx_if.slave  bus,
    output logic         sclk,
    output logic         mosi,
    output logic         cs_n
`ifdef SPI_DAC_LDAC_EN
    ,
    output logic         ldac_n
`endif
);

    localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > LDAC_WIDTH) ? CS_SETUP : LDAC_WIDTH)
                           : ((CS_HOLD  > LDAC_WIDTH) ? CS_HOLD  : LDAC_WIDTH);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [FRAME_BITS-1:0]  frame_in;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]       cnt;
    logic                   shift_en;
    logic                   rise_tick;
    logic                   fall_tick;
    logic                   busy_q;
    logic                   done_q;

    assign frame_in = build_frame(CMD, bus.data);
    assign shift_en = (state == ST_SHIFT);
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (shift_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sclk      (sclk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            // NOTE: the shift register is a plain register, not a memory, so it is reset with the rest.
            shreg   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
            ldac_n  <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                // A request landing in the done cycle is dropped so cs_n always sees a high gap.
                ST_IDLE: begin
                    if (bus.start && !done_q) begin
                        shreg   <= frame_in;
                        mosi    <= frame_in[FRAME_BITS-1];
                        cs_n    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // bit_cnt counts rises and wraps to zero on the 16th, marking the last bit.
                ST_SHIFT: begin
                    if (rise_tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (fall_tick) begin
                        if (bit_cnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            shreg <= shreg << 1;
                            mosi  <= shreg[FRAME_BITS-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == CNT_W'(CS_HOLD - 1)) begin
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
                        state <= ST_LDAC;
`else
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SPI_DAC_LDAC_EN
                // First LDAC cycle is the cs_n-high gap; the strobe then spans LDAC_WIDTH cycles.
                ST_LDAC: begin
                    if (cnt == CNT_W'(LDAC_WIDTH)) begin
                        cnt    <= '0;
                        ldac_n <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        ldac_n <= 1'b0;
                        cnt    <= cnt + 1'b1;
                    end
                end
`endif
                // NOTE: a default arm keeps unused encodings recoverable and the case fully specified.
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_tx.sv
// Self-checking bench for spi_dac_tx: directed and randomized frames against a timing/frame model
// derived from the frame rules; covers the LDAC strobe when SPI_DAC_LDAC_EN is defined.
module tb_spi_dac_tx;

    localparam int         CLK_DIV    = 4;
    localparam int         CS_SETUP   = 2;
    localparam int         CS_HOLD    = 2;
    localparam int         LDAC_WIDTH = 2;
    localparam logic [3:0] CMD        = 4'h3;

    // Offsets counted in negedge samples after the cycle in which start is accepted.
    localparam int CS_LOW_T = CS_SETUP + 2 * 16 * CLK_DIV + CS_HOLD;
`ifdef SPI_DAC_LDAC_EN
    localparam int DONE_T = CS_LOW_T + 2 + LDAC_WIDTH;
`else
    localparam int DONE_T = CS_LOW_T + 1;
`endif

    logic clk;
    logic reset;
    logic sclk;
    logic mosi;
    logic cs_n;
`ifdef SPI_DAC_LDAC_EN
    logic ldac_n;
`endif

    spi_dac_tx_if bus ();

    spi_dac_tx #(
        .CLK_DIV    (CLK_DIV),
        .CS_SETUP   (CS_SETUP),
        .CS_HOLD    (CS_HOLD),
        .CMD        (CMD),
        .LDAC_WIDTH (LDAC_WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs_n   (cs_n)
`ifdef SPI_DAC_LDAC_EN
        ,
        .ldac_n (ldac_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and observe the whole frame plus a short quiet window after done.
    task automatic run_frame(input string name, input logic [7:0] d, input int start_len,
                             input int change_at, input logic [7:0] d2);
        int          cs_low, cs_first, busy_cnt, done_cnt, done_t, rises, idle_sclk;
        int          ldac_low, ldac_first;
        logic [15:0] bits;
        logic        prev_sclk, done_mosi;
        cs_low = 0; cs_first = 0; busy_cnt = 0; done_cnt = 0; done_t = 0;
        rises = 0; idle_sclk = 0; ldac_low = 0; ldac_first = 0;
        bits = '0; prev_sclk = 1'b0; done_mosi = 1'b1;
        bus.data  = d;
        bus.start = 1'b1;
        for (int t = 1; t <= DONE_T + 40; t++) begin
            @(negedge clk);
            if (!cs_n) begin
                cs_low++;
                if (cs_first == 0) cs_first = t;
            end else if (sclk) begin
                idle_sclk++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (done_cnt == 0) begin
                    done_t    = t;
                    done_mosi = mosi;
                end
                done_cnt++;
            end
            if (sclk && !prev_sclk) begin
                bits = {bits[14:0], mosi};
                rises++;
            end
            prev_sclk = sclk;
`ifdef SPI_DAC_LDAC_EN
            if (!ldac_n) begin
                ldac_low++;
                if (ldac_first == 0) ldac_first = t;
            end
`endif
            if (t == start_len) bus.start = 1'b0;
            if (t == change_at) bus.data = d2;
            if (done_cnt != 0 && t >= done_t + 6) break;
        end
        bus.start = 1'b0;
        check({name, "_bits"},      32'(bits),      32'({CMD, d, 4'h0}));
        check({name, "_rises"},     32'(rises),     32'd16);
        check({name, "_cs_first"},  32'(cs_first),  32'd1);
        check({name, "_cs_low"},    32'(cs_low),    32'(CS_LOW_T));
        check({name, "_busy"},      32'(busy_cnt),  32'(DONE_T - 1));
        check({name, "_done_cnt"},  32'(done_cnt),  32'd1);
        check({name, "_done_t"},    32'(done_t),    32'(DONE_T));
        check({name, "_done_mosi"}, 32'(done_mosi), 32'd0);
        check({name, "_idle_sclk"}, 32'(idle_sclk), 32'd0);
`ifdef SPI_DAC_LDAC_EN
        check({name, "_ldac_first"}, 32'(ldac_first), 32'(CS_LOW_T + 2));
        check({name, "_ldac_low"},   32'(ldac_low),   32'(LDAC_WIDTH));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          first_done, second_done, rises_seen, quiet_bad;
    logic        prev;
    logic [7:0]  rd, rd2;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.data  = 8'h00;
        #2;
        check("rst_cs_n", 32'(cs_n),     32'd1);
        check("rst_sclk", 32'(sclk),     32'd0);
        check("rst_mosi", 32'(mosi),     32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
`ifdef SPI_DAC_LDAC_EN
        check("rst_ldac", 32'(ldac_n),   32'd1);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_frame("a5", 8'hA5, 1, 0, 8'h00);
        run_frame("hold4", 8'h00, 4, 0, 8'h00);
        run_frame("midchg", 8'hFF, 1, 60, 8'h12);

        // Continuous start: the done-cycle request is dropped, next frame accepted one cycle later.
        bus.data   = 8'h3C;
        bus.start  = 1'b1;
        first_done = 0;
        for (int t = 1; t <= DONE_T + 10; t++) begin
            @(negedge clk);
            if (bus.done) begin
                first_done = t;
                break;
            end
        end
        check("cont_done1_t", 32'(first_done), 32'(DONE_T));
        @(negedge clk);
        check("cont_cs_done_p1", 32'(cs_n), 32'd1);
        @(negedge clk);
        check("cont_cs_done_p2", 32'(cs_n), 32'd0);
        bus.start   = 1'b0;
        second_done = 0;
        for (int t = 2; t <= DONE_T + 10; t++) begin
            @(negedge clk);
            if (bus.done) begin
                second_done = t;
                break;
            end
        end
        check("cont_done2_t", 32'(second_done), 32'(DONE_T));
        @(negedge clk);
        @(negedge clk);

        // Asynchronous abort after the 7th rising sclk edge.
        bus.data   = 8'hC3;
        bus.start  = 1'b1;
        rises_seen = 0;
        prev       = 1'b0;
        for (int t = 1; t <= DONE_T; t++) begin
            @(negedge clk);
            if (t == 1) bus.start = 1'b0;
            if (sclk && !prev) rises_seen++;
            prev = sclk;
            if (rises_seen == 7) break;
        end
        check("abort_rises_seen", 32'(rises_seen), 32'd7);
        #1 reset = 1'b1;
        #1;
        check("abort_cs_n", 32'(cs_n),     32'd1);
        check("abort_sclk", 32'(sclk),     32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        quiet_bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.done || !cs_n) quiet_bad++;
        end
        check("abort_no_done", 32'(quiet_bad), 32'd0);
        run_frame("after_abort", 8'h5A, 1, 0, 8'h00);

        // Randomized requests: code, request length, mid-frame data change and idle gap.
        for (int i = 0; i < 10; i++) begin
            rd  = 8'($urandom);
            rd2 = 8'($urandom);
            run_frame($sformatf("rnd%0d", i), rd, int'($urandom_range(1, 8)),
                      int'($urandom_range(1, 130)), rd2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
